conv_loop_ctrl: RTL and testbench

CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

---
 rtl/conv_ctrl_pkg.sv | 17 +
 rtl/conv_valid_delay.sv | 41 ++++
 rtl/conv_loop_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_conv_loop_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and limits for the convolution loop controller.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int MAC_LATENCY_MAX = 8;

    // Counter width able to hold 0 .. bound-1 (at least one bit).
    function automatic int cnt_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/conv_valid_delay.sv
// Fixed-depth shift line for a valid strobe and its payload; the payload of a
// stage only moves when its valid bit is set, so the output holds between strobes.
module conv_valid_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/conv_loop_ctrl.sv
// Convolution loop-nest controller: walks x, y, ch_in, ch_out, k_v, k_h and schedules
// MAC, partial-sum and result strobes. Define CONV_LOOP_CTRL_PERF_CNT_EN for perf counters.
//
// state    | meaning
// ST_IDLE  | waiting for start, all strobes low
// ST_RUN   | stepping the loop nest on every fire (a_valid & b_valid)
// ST_DRAIN | no new steps, waiting MAC_LATENCY cycles for in-flight results
module conv_loop_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int MAC_LATENCY        = 4
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          running,
    output logic                          done,
    input  logic                          a_valid,
    input  logic                          b_valid,
    output logic                          a_ready,
    output logic                          b_ready,
    output logic                          write_a,
    output logic                          write_b,
    output logic                          mac_valid,
    output logic                          mac_accumulate_internal,
    output logic                          mac_accumulate_with_0,
    output logic                          mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
    output logic                          mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    output logic                          output_valid,
    output logic [31:0]                   output_x,
    output logic [31:0]                   output_y,
    output logic [31:0]                   output_ch
`ifdef CONV_LOOP_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_busy_cycles,
    output logic [31:0]                   perf_stall_cycles
`endif
);

    localparam int XW = cnt_width(FEATURE_MAP_WIDTH);
    localparam int YW = cnt_width(FEATURE_MAP_HEIGHT);
    localparam int IW = cnt_width(INPUT_NB_CHANNELS);
    localparam int OW = cnt_width(OUTPUT_NB_CHANNELS);
    localparam int KW = cnt_width(KERNEL_SIZE);
    localparam int DW = $clog2(MAC_LATENCY_MAX);

    state_t          state;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [IW-1:0]   ci_cnt;
    logic [OW-1:0]   co_cnt;
    logic [KW-1:0]   kv_cnt;
    logic [KW-1:0]   kh_cnt;
    logic [DW-1:0]   drain_cnt;

    logic run, fire;
    logic x_last, y_last, ci_last, co_last, kv_last, kh_last;
    logic c_co, c_ci, c_y, c_x, last_step;
    logic first_tap, last_tap;
    logic psum_ev, res_ev;
    logic [95:0] res_in, res_out;

    assign run  = (state == ST_RUN);
    assign fire = run & a_valid & b_valid;

    assign x_last  = (x_cnt  == XW'(FEATURE_MAP_WIDTH - 1));
    assign y_last  = (y_cnt  == YW'(FEATURE_MAP_HEIGHT - 1));
    assign ci_last = (ci_cnt == IW'(INPUT_NB_CHANNELS - 1));
    assign co_last = (co_cnt == OW'(OUTPUT_NB_CHANNELS - 1));
    assign kv_last = (kv_cnt == KW'(KERNEL_SIZE - 1));
    assign kh_last = (kh_cnt == KW'(KERNEL_SIZE - 1));

    // Carry chain: each level moves only when everything inside it is at its last value.
    assign c_co      = kh_last & kv_last;
    assign c_ci      = c_co & co_last;
    assign c_y       = c_ci & ci_last;
    assign c_x       = c_y & y_last;
    assign last_step = c_x & x_last;

    assign first_tap = (kv_cnt == '0) && (kh_cnt == '0);
    assign last_tap  = kh_last & kv_last;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state     <= ST_IDLE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            ci_cnt    <= '0;
            co_cnt    <= '0;
            kv_cnt    <= '0;
            kh_cnt    <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        kh_cnt <= kh_last ? '0 : kh_cnt + 1'b1;
                        if (kh_last) kv_cnt <= kv_last ? '0 : kv_cnt + 1'b1;
                        if (c_co)    co_cnt <= co_last ? '0 : co_cnt + 1'b1;
                        if (c_ci)    ci_cnt <= ci_last ? '0 : ci_cnt + 1'b1;
                        if (c_y)     y_cnt  <= y_last  ? '0 : y_cnt + 1'b1;
                        if (c_x)     x_cnt  <= x_last  ? '0 : x_cnt + 1'b1;
                        if (last_step) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DW'(MAC_LATENCY - 1);
                            done      <= (MAC_LATENCY == 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // done lands in the final drain cycle, alongside the last result
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        done      <= (drain_cnt == DW'(1));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign running = (state != ST_IDLE);
    assign a_ready = run;
    assign b_ready = run;
    assign write_a = run;
    assign write_b = run;

    assign mac_valid               = fire;
    assign mac_accumulate_internal = run & ~first_tap;
    assign mac_accumulate_with_0   = run & first_tap & (ci_cnt == '0);
    assign mem_re                  = fire & first_tap & (ci_cnt != '0);
    assign mem_read_addr           = LOG2_OF_MEM_HEIGHT'(co_cnt);

    assign psum_ev = fire & last_tap & ~ci_last;
    assign res_ev  = fire & last_tap & ci_last;
    assign res_in  = {32'(x_cnt), 32'(y_cnt), 32'(co_cnt)};

    conv_valid_delay #(
        .DEPTH (MAC_LATENCY),
        .WIDTH (LOG2_OF_MEM_HEIGHT)
    ) u_psum_delay (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .in_valid  (psum_ev),
        .in_data   (LOG2_OF_MEM_HEIGHT'(co_cnt)),
        .out_valid (mem_we),
        .out_data  (mem_write_addr)
    );

    conv_valid_delay #(
        .DEPTH (MAC_LATENCY),
        .WIDTH (96)
    ) u_res_delay (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .in_valid  (res_ev),
        .in_data   (res_in),
        .out_valid (output_valid),
        .out_data  (res_out)
    );

    assign output_x  = res_out[95:64];
    assign output_y  = res_out[63:32];
    assign output_ch = res_out[31:0];

`ifdef CONV_LOOP_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (state == ST_IDLE && start) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state != ST_IDLE && perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (run && !fire && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Directed bench for conv_loop_ctrl: three instances (K=3/LAT=4, K=1/LAT=1, K=1/LAT=8)
// checked cycle by cycle against a step-index decode of the loop nest.
`timescale 1ns/1ps
module tb_conv_loop_ctrl;

    localparam int FMW = 2;
    localparam int FMH = 2;

    int cin_p[3] = '{2, 1, 1};
    int cout_p[3] = '{2, 2, 2};
    int k_p[3] = '{3, 1, 1};
    int lat_p[3] = '{4, 1, 8};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start0 = 1'b0, av0 = 1'b0, bv0 = 1'b0;
    logic start1 = 1'b0, v1 = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    bit hist_v[3][16];
    int hist_n[3][16];
    int nfire[3];
    int cnt_mv[3], cnt_we[3], cnt_ov[3], cnt_re[3], cnt_dn[3];

    logic run_0, dn_0, ar_0, br_0, wa_0, wb_0, mv_0, ai_0, a0_0, we_0, re_0, ov_0;
    logic run_1, dn_1, ar_1, br_1, wa_1, wb_1, mv_1, ai_1, a0_1, we_1, re_1, ov_1;
    logic run_2, dn_2, ar_2, br_2, wa_2, wb_2, mv_2, ai_2, a0_2, we_2, re_2, ov_2;
    logic [19:0] wad_0, rad_0, wad_1, rad_1, wad_2, rad_2;
    logic [31:0] ox_0, oy_0, och_0, ox_1, oy_1, och_1, ox_2, oy_2, och_2;
`ifdef CONV_LOOP_CTRL_PERF_CNT_EN
    logic [31:0] pb_0, ps_0, pb_1, ps_1, pb_2, ps_2;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv_loop_ctrl #(.LOG2_OF_MEM_HEIGHT(20), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
                     .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3), .MAC_LATENCY(4)) dut0 (
        .clk(clk), .arst_n_in(rst_n), .start(start0), .running(run_0), .done(dn_0),
        .a_valid(av0), .b_valid(bv0), .a_ready(ar_0), .b_ready(br_0), .write_a(wa_0), .write_b(wb_0),
        .mac_valid(mv_0), .mac_accumulate_internal(ai_0), .mac_accumulate_with_0(a0_0),
        .mem_we(we_0), .mem_write_addr(wad_0), .mem_re(re_0), .mem_read_addr(rad_0),
        .output_valid(ov_0), .output_x(ox_0), .output_y(oy_0), .output_ch(och_0)
`ifdef CONV_LOOP_CTRL_PERF_CNT_EN
        , .perf_busy_cycles(pb_0), .perf_stall_cycles(ps_0)
`endif
    );

    conv_loop_ctrl #(.LOG2_OF_MEM_HEIGHT(20), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
                     .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .MAC_LATENCY(1)) dut1 (
        .clk(clk), .arst_n_in(rst_n), .start(start1), .running(run_1), .done(dn_1),
        .a_valid(v1), .b_valid(v1), .a_ready(ar_1), .b_ready(br_1), .write_a(wa_1), .write_b(wb_1),
        .mac_valid(mv_1), .mac_accumulate_internal(ai_1), .mac_accumulate_with_0(a0_1),
        .mem_we(we_1), .mem_write_addr(wad_1), .mem_re(re_1), .mem_read_addr(rad_1),
        .output_valid(ov_1), .output_x(ox_1), .output_y(oy_1), .output_ch(och_1)
`ifdef CONV_LOOP_CTRL_PERF_CNT_EN
        , .perf_busy_cycles(pb_1), .perf_stall_cycles(ps_1)
`endif
    );

    conv_loop_ctrl #(.LOG2_OF_MEM_HEIGHT(20), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
                     .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .MAC_LATENCY(8)) dut2 (
        .clk(clk), .arst_n_in(rst_n), .start(start1), .running(run_2), .done(dn_2),
        .a_valid(v1), .b_valid(v1), .a_ready(ar_2), .b_ready(br_2), .write_a(wa_2), .write_b(wb_2),
        .mac_valid(mv_2), .mac_accumulate_internal(ai_2), .mac_accumulate_with_0(a0_2),
        .mem_we(we_2), .mem_write_addr(wad_2), .mem_re(re_2), .mem_read_addr(rad_2),
        .output_valid(ov_2), .output_x(ox_2), .output_y(oy_2), .output_ch(och_2)
`ifdef CONV_LOOP_CTRL_PERF_CNT_EN
        , .perf_busy_cycles(pb_2), .perf_stall_cycles(ps_2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int total(input int d);
        return FMW * FMH * cin_p[d] * cout_p[d] * k_p[d] * k_p[d];
    endfunction

    // Mixed-radix decode of a step index, k_h least significant, x most significant.
    function automatic void decode(input int d, input int n,
                                   output int x, output int y, output int ci,
                                   output int co, output int kv, output int kh);
        int r;
        r  = n;
        kh = r % k_p[d];    r = r / k_p[d];
        kv = r % k_p[d];    r = r / k_p[d];
        co = r % cout_p[d]; r = r / cout_p[d];
        ci = r % cin_p[d];  r = r / cin_p[d];
        y  = r % FMH;
        x  = r / FMH;
    endfunction

    task automatic clr_model(input int d);
        for (int i = 0; i < 16; i++) hist_v[d][i] = 1'b0;
        nfire[d] = 0;
        cnt_mv[d] = 0; cnt_we[d] = 0; cnt_ov[d] = 0; cnt_re[d] = 0; cnt_dn[d] = 0;
    endtask

    task automatic mon(input int d, input logic mv, input logic re, input logic ai, input logic a0,
                       input logic we, input logic ov, input logic dn,
                       input logic [31:0] rad, input logic [31:0] wad,
                       input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] och);
        int x, y, ci, co, kv, kh, slot;
        bit e_ov, e_we, e_dn;
        if (mv) begin
            decode(d, nfire[d], x, y, ci, co, kv, kh);
            chk($sformatf("d%0d.step_in_range", d), 32'(nfire[d] < total(d)), 32'd1);
            chk($sformatf("d%0d.mem_re", d), 32'(re), 32'(kv == 0 && kh == 0 && ci != 0));
            chk($sformatf("d%0d.acc_internal", d), 32'(ai), 32'(!(kv == 0 && kh == 0)));
            chk($sformatf("d%0d.acc_with_0", d), 32'(a0), 32'(kv == 0 && kh == 0 && ci == 0));
            if (re) chk($sformatf("d%0d.rd_addr", d), rad, 32'(co));
            hist_v[d][cyc & 15] = 1'b1;
            hist_n[d][cyc & 15] = nfire[d];
            nfire[d]++;
            cnt_mv[d]++;
        end else begin
            hist_v[d][cyc & 15] = 1'b0;
            chk($sformatf("d%0d.mem_re_nofire", d), 32'(re), 32'd0);
        end
        e_ov = 1'b0; e_we = 1'b0; e_dn = 1'b0;
        slot = (cyc - lat_p[d]) & 15;
        if (cyc >= lat_p[d] && hist_v[d][slot]) begin
            decode(d, hist_n[d][slot], x, y, ci, co, kv, kh);
            if (kv == k_p[d] - 1 && kh == k_p[d] - 1) begin
                e_ov = (ci == cin_p[d] - 1);
                e_we = !e_ov;
            end
            e_dn = (hist_n[d][slot] == total(d) - 1);
        end
        chk($sformatf("d%0d.output_valid", d), 32'(ov), 32'(e_ov));
        chk($sformatf("d%0d.mem_we", d), 32'(we), 32'(e_we));
        chk($sformatf("d%0d.done", d), 32'(dn), 32'(e_dn));
        if (e_ov) begin
            chk($sformatf("d%0d.output_x", d), ox, 32'(x));
            chk($sformatf("d%0d.output_y", d), oy, 32'(y));
            chk($sformatf("d%0d.output_ch", d), och, 32'(co));
        end
        if (e_we) chk($sformatf("d%0d.wr_addr", d), wad, 32'(co));
        if (we) cnt_we[d]++;
        if (ov) cnt_ov[d]++;
        if (re) cnt_re[d]++;
        if (dn) cnt_dn[d]++;
    endtask

    always @(negedge clk) begin
        mon(0, mv_0, re_0, ai_0, a0_0, we_0, ov_0, dn_0, 32'(rad_0), 32'(wad_0), ox_0, oy_0, och_0);
        mon(1, mv_1, re_1, ai_1, a0_1, we_1, ov_1, dn_1, 32'(rad_1), 32'(wad_1), ox_1, oy_1, och_1);
        mon(2, mv_2, re_2, ai_2, a0_2, we_2, ov_2, dn_2, 32'(rad_2), 32'(wad_2), ox_2, oy_2, och_2);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_d0();
        clr_model(0);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input string tag, input bit toggle);
        int i;
        i = 0;
        while (cnt_dn[0] == 0 && i < 800) begin
            if (toggle) av0 = ~av0;
            tick(1);
            i++;
        end
        chk(tag, 32'(cnt_dn[0] != 0), 32'd1);
    endtask

    task automatic check_counts0(input string tag);
        chk({tag, ".mac_valid"}, 32'(cnt_mv[0]), 32'd144);
        chk({tag, ".mem_we"}, 32'(cnt_we[0]), 32'd8);
        chk({tag, ".output_valid"}, 32'(cnt_ov[0]), 32'd8);
        chk({tag, ".done_pulses"}, 32'(cnt_dn[0]), 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) clr_model(d);
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst.running", 32'(run_0), 32'd0);
        chk("rst.a_ready", 32'(ar_0), 32'd0);
        chk("rst.acc_with_0", 32'(a0_0), 32'd0);
        chk("rst.output_x", ox_0, 32'd0);
        chk("rst.wr_addr", 32'(wad_0), 32'd0);
        rst_n = 1'b1;
        tick(3);
        chk("idle.running", 32'(run_0), 32'd0);

        // full run, valids held high
        av0 = 1'b1; bv0 = 1'b1;
        start_d0();
        chk("s1.running", 32'(run_0), 32'd1);
        chk("s1.a_ready", 32'(ar_0), 32'd1);
        chk("s1.write_b", 32'(wb_0), 32'd1);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        wait_done0("s1.done_timeout", 1'b0);
        tick(3);
        check_counts0("s1");
        chk("s1.running_end", 32'(run_0), 32'd0);
        chk("s1.hold_x", ox_0, 32'd1);
        chk("s1.hold_y", oy_0, 32'd1);
        chk("s1.hold_ch", och_0, 32'd1);
        chk("s1.hold_wr_addr", 32'(wad_0), 32'd1);

        // a_valid alternating, high in the first RUN cycle
        av0 = 1'b0;
        start_d0();
        wait_done0("s2.done_timeout", 1'b1);
        tick(3);
        check_counts0("s2");
`ifdef CONV_LOOP_CTRL_PERF_CNT_EN
        chk("s2.perf_stall", ps_0, 32'd143);
        chk("s2.perf_busy", pb_0, 32'd291);
`endif
        av0 = 1'b1;

        // reset during step 50, then a clean rerun
        start_d0();
        for (int i = 0; i < 200 && nfire[0] < 50; i++) tick(1);
        chk("s5.reached_step50", 32'(nfire[0]), 32'd50);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) clr_model(d);
        tick(3);
        chk("s5.running_in_rst", 32'(run_0), 32'd0);
        rst_n = 1'b1;
        tick(8);
        chk("s5.no_mac_after_rst", 32'(cnt_mv[0]), 32'd0);
        chk("s5.no_ov_after_rst", 32'(cnt_ov[0] + cnt_we[0]), 32'd0);
        chk("s5.output_x_cleared", ox_0, 32'd0);
        start_d0();
        wait_done0("s5.done_timeout", 1'b0);
        tick(3);
        check_counts0("s5");

        // start pulsed in the first DRAIN cycle is ignored
        start_d0();
        for (int i = 0; i < 300 && nfire[0] < 144; i++) tick(1);
        chk("s6.all_steps", 32'(nfire[0]), 32'd144);
        chk("s6.running_drain", 32'(run_0), 32'd1);
        chk("s6.a_ready_drain", 32'(ar_0), 32'd0);
        chk("s6.mac_valid_drain", 32'(mv_0), 32'd0);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        wait_done0("s6.done_timeout", 1'b0);
        tick(20);
        check_counts0("s6");
        chk("s6.running_end", 32'(run_0), 32'd0);

        // K=1, CH_IN=1 at latencies 1 and 8
        clr_model(1);
        clr_model(2);
        v1 = 1'b1;
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        for (int i = 0; i < 60 && (cnt_dn[1] == 0 || cnt_dn[2] == 0); i++) tick(1);
        tick(3);
        chk("s3.lat1.mac_valid", 32'(cnt_mv[1]), 32'd8);
        chk("s3.lat1.output_valid", 32'(cnt_ov[1]), 32'd8);
        chk("s3.lat1.mem_we", 32'(cnt_we[1]), 32'd0);
        chk("s3.lat1.mem_re", 32'(cnt_re[1]), 32'd0);
        chk("s3.lat1.done", 32'(cnt_dn[1]), 32'd1);
        chk("s4.lat8.mac_valid", 32'(cnt_mv[2]), 32'd8);
        chk("s4.lat8.output_valid", 32'(cnt_ov[2]), 32'd8);
        chk("s4.lat8.mem_re", 32'(cnt_re[2]), 32'd0);
        chk("s4.lat8.done", 32'(cnt_dn[2]), 32'd1);
        chk("s4.running_end", 32'(run_1 | run_2), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
